// File: rtl/hyst_monitor_pkg.sv
// Shared types and helpers for the hysteresis threshold monitor.
//   state_e    : filtered-state FSM encoding
//   cnt_width  : bits needed to count 0..persist
package hyst_monitor_pkg;

  typedef enum logic [1:0] {
    BELOW   = 2'd0,
    PEND_UP = 2'd1,
    ABOVE   = 2'd2,
    PEND_DN = 2'd3
  } state_e;

  // ceil(log2(persist+1)), minimum 1
  function automatic int unsigned cnt_width(input int unsigned persist);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < persist + 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/hyst_threshold_monitor_band_compare.sv
// Combinational band / compare logic for the threshold monitor.
// Ports:
//   data      : unsigned sample
//   thr, hyst : threshold T and hysteresis half-band H
//   eq/gt/lt  : sample ==, >, < T
//   rise_cond : sample > min(T+H, max)
//   fall_cond : sample < max(T-H, 0)
module band_compare #(
  parameter int unsigned DATA_WIDTH = 13
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] thr,
  input  logic [DATA_WIDTH-1:0] hyst,
  output logic                  eq,
  output logic                  gt,
  output logic                  lt,
  output logic                  rise_cond,
  output logic                  fall_cond
);

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] upper;
  logic [DATA_WIDTH-1:0] lower;

  always_comb begin
    sum   = {1'b0, thr} + {1'b0, hyst};
    diff  = {1'b0, thr} - {1'b0, hyst};
    // carry out of T+H saturates high; borrow out of T-H saturates low
    upper = sum[DATA_WIDTH]  ? '1 : sum[DATA_WIDTH-1:0];
    lower = diff[DATA_WIDTH] ? '0 : diff[DATA_WIDTH-1:0];
    eq        = (data == thr);
    gt        = (data > thr);
    lt        = (data < thr);
    rise_cond = (data > upper);
    fall_cond = (data < lower);
  end

endmodule

// File: rtl/hyst_threshold_monitor.sv
// Registered threshold comparator with hysteresis and persistence filter.
// Ports:
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_valid, i_data_A     : sample qualifier and unsigned sample
//   i_thr_load, i_thr,
//   i_hyst                : load new threshold T and hysteresis H
//   o_valid               : registered i_valid
//   o_aeb/o_agb/o_alb     : sample ==, >, < T (held when idle)
//   o_above               : filtered state, 1 = above
//   o_rise/o_fall         : one-cycle transition pulses
module hyst_threshold_monitor
  import hyst_monitor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 13,
  parameter int unsigned THRESH_DEFAULT = 10,
  parameter int unsigned HYST_DEFAULT   = 0,
  parameter int unsigned PERSIST        = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data_A,
  input  logic                  i_thr_load,
  input  logic [DATA_WIDTH-1:0] i_thr,
  input  logic [DATA_WIDTH-1:0] i_hyst,
  output logic                  o_valid,
  output logic                  o_aeb,
  output logic                  o_agb,
  output logic                  o_alb,
  output logic                  o_above,
  output logic                  o_rise,
  output logic                  o_fall
);

  localparam int unsigned CW = cnt_width(PERSIST);

  logic [DATA_WIDTH-1:0] thr_q, thr_d;
  logic [DATA_WIDTH-1:0] hyst_q, hyst_d;
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  aeb_q, aeb_d;
  logic                  agb_q, agb_d;
  logic                  alb_q, alb_d;
  logic                  above_q, above_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;

  logic eq, gt, lt, rise_cond, fall_cond;

  band_compare #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_band (
    .data      (i_data_A),
    .thr       (thr_q),
    .hyst      (hyst_q),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .rise_cond (rise_cond),
    .fall_cond (fall_cond)
  );

  always_comb begin
    thr_d   = thr_q;
    hyst_d  = hyst_q;
    valid_d = i_valid;
    aeb_d   = aeb_q;
    agb_d   = agb_q;
    alb_d   = alb_q;
    if (i_thr_load) begin
      thr_d  = i_thr;
      hyst_d = i_hyst;
    end
    if (i_valid) begin
      aeb_d = eq;
      agb_d = gt;
      alb_d = lt;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // A load abandons any pending transition; stable states still evaluate
    // the same-cycle sample against the old T/H.
    if (i_thr_load && state_q == PEND_UP) begin
      state_d = BELOW;
      cnt_d   = '0;
    end else if (i_thr_load && state_q == PEND_DN) begin
      state_d = ABOVE;
      cnt_d   = '0;
    end else if (i_valid) begin
      unique case (state_q)
        BELOW: begin
          if (rise_cond) begin
            if (PERSIST == 1) begin
              state_d = ABOVE;
              rise_d  = 1'b1;
            end else begin
              state_d = PEND_UP;
              cnt_d   = CW'(1);
            end
          end
        end
        PEND_UP: begin
          if (!rise_cond) begin
            state_d = BELOW;
            cnt_d   = '0;
          end else if (cnt_q == CW'(PERSIST - 1)) begin
            state_d = ABOVE;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ABOVE: begin
          if (fall_cond) begin
            if (PERSIST == 1) begin
              state_d = BELOW;
              fall_d  = 1'b1;
            end else begin
              state_d = PEND_DN;
              cnt_d   = CW'(1);
            end
          end
        end
        PEND_DN: begin
          if (!fall_cond) begin
            state_d = ABOVE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(PERSIST - 1)) begin
            state_d = BELOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = BELOW;
          cnt_d   = '0;
        end
      endcase
    end
    above_d = (state_d == ABOVE) || (state_d == PEND_DN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      thr_q   <= DATA_WIDTH'(THRESH_DEFAULT);
      hyst_q  <= DATA_WIDTH'(HYST_DEFAULT);
      state_q <= BELOW;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      aeb_q   <= 1'b0;
      agb_q   <= 1'b0;
      alb_q   <= 1'b0;
      above_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      thr_q   <= thr_d;
      hyst_q  <= hyst_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      aeb_q   <= aeb_d;
      agb_q   <= agb_d;
      alb_q   <= alb_d;
      above_q <= above_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_valid = valid_q;
  assign o_aeb   = aeb_q;
  assign o_agb   = agb_q;
  assign o_alb   = alb_q;
  assign o_above = above_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: tb/tb_hyst_threshold_monitor.sv
// Bench for hyst_threshold_monitor: behavioural model plus directed vectors.
module tb_hyst_threshold_monitor;

  localparam int W       = 13;
  localparam int T0      = 10;
  localparam int H0      = 2;
  localparam int PERSIST = 3;
  localparam int MAXV    = (1 << W) - 1;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_valid;
  logic [W-1:0] i_data_A;
  logic         i_thr_load;
  logic [W-1:0] i_thr;
  logic [W-1:0] i_hyst;
  logic o_valid, o_aeb, o_agb, o_alb, o_above, o_rise, o_fall;

  hyst_threshold_monitor #(
    .DATA_WIDTH    (W),
    .THRESH_DEFAULT(T0),
    .HYST_DEFAULT  (H0),
    .PERSIST       (PERSIST)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .i_data_A  (i_data_A),
    .i_thr_load(i_thr_load),
    .i_thr     (i_thr),
    .i_hyst    (i_hyst),
    .o_valid   (o_valid),
    .o_aeb     (o_aeb),
    .o_agb     (o_agb),
    .o_alb     (o_alb),
    .o_above   (o_above),
    .o_rise    (o_rise),
    .o_fall    (o_fall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: threshold/hysteresis as integers, filtered state as a bit and a
  // run length of consecutive qualifying samples.
  int m_t, m_h, m_run, up, lo, d;
  bit m_above, q;
  bit e_valid, e_aeb, e_agb, e_alb, e_rise, e_fall;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_t = T0; m_h = H0; m_run = 0; m_above = 0;
      e_valid = 0; e_aeb = 0; e_agb = 0; e_alb = 0; e_rise = 0; e_fall = 0;
    end else begin
      up = (m_t + m_h > MAXV) ? MAXV : m_t + m_h;
      lo = (m_t - m_h < 0) ? 0 : m_t - m_h;
      d  = int'(i_data_A);
      e_valid = i_valid;
      e_rise  = 0;
      e_fall  = 0;
      if (i_valid) begin
        e_aeb = (d == m_t);
        e_agb = (d > m_t);
        e_alb = (d < m_t);
      end
      if (i_thr_load && m_run > 0) begin
        m_run = 0;
      end else if (i_valid) begin
        q = m_above ? (d < lo) : (d > up);
        if (q) begin
          m_run++;
          if (m_run == PERSIST) begin
            m_above = !m_above;
            if (m_above) e_rise = 1; else e_fall = 1;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      if (i_thr_load) begin
        m_t = int'(i_thr);
        m_h = int'(i_hyst);
      end
    end
  end

  bit run_cmp = 0;
  always @(negedge i_clk) begin
    if (run_cmp) begin
      chk("valid", o_valid, e_valid);
      chk("aeb",   o_aeb,   e_aeb);
      chk("agb",   o_agb,   e_agb);
      chk("alb",   o_alb,   e_alb);
      chk("above", o_above, m_above);
      chk("rise",  o_rise,  e_rise);
      chk("fall",  o_fall,  e_fall);
    end
  end

  // Apply inputs at a falling edge, return at the next falling edge when
  // the outputs for this sample are visible.
  task automatic cyc(input logic v, input int data, input logic ld = 0,
                     input int t = T0, input int h = H0);
    i_valid    = v;
    i_data_A   = W'(data);
    i_thr_load = ld;
    i_thr      = W'(t);
    i_hyst     = W'(h);
    @(negedge i_clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 1'b0);
    chk({tag, "_aeb"},   o_aeb,   1'b0);
    chk({tag, "_agb"},   o_agb,   1'b0);
    chk({tag, "_alb"},   o_alb,   1'b0);
    chk({tag, "_above"}, o_above, 1'b0);
    chk({tag, "_rise"},  o_rise,  1'b0);
    chk({tag, "_fall"},  o_fall,  1'b0);
  endtask

  initial begin
    i_rst_n = 0; i_valid = 1; i_data_A = W'(500);
    i_thr_load = 0; i_thr = W'(T0); i_hyst = W'(H0);
    @(negedge i_clk);
    run_cmp = 1;
    cyc(1, 500);
    cyc(1, 500);
    chk_all_zero("rst_hold");
    i_rst_n = 1;
    cyc(0, 500);
    chk("post_rst_idle_valid", o_valid, 1'b0);
    cyc(1, 500);
    chk("first_valid", o_valid, 1'b1);
    chk("first_agb",   o_agb,   1'b1);

    // flags with the filter idle (BELOW, nothing above 12)
    cyc(1, 10);  chk("eq10",  o_aeb, 1'b1);
    cyc(1, 11);  chk("gt11",  o_agb, 1'b1);
    cyc(1, 9);   chk("lt9",   o_alb, 1'b1);
    cyc(0, 0);   chk("idle_valid", o_valid, 1'b0);
                 chk("idle_hold",  o_alb,   1'b1);

    // broken run: 13,13,11 returns to BELOW
    cyc(1, 13); cyc(1, 13); cyc(1, 11);
    chk("broken_rise",  o_rise,  1'b0);
    chk("broken_above", o_above, 1'b0);

    // clean run of three
    cyc(1, 13); cyc(1, 13);
    chk("pend_no_rise", o_rise, 1'b0);
    cyc(1, 13);
    chk("rise_pulse", o_rise,  1'b1);
    chk("rise_above", o_above, 1'b1);
    cyc(0, 0);
    chk("rise_one_cycle", o_rise, 1'b0);

    // 9 is not below lower band 8
    cyc(1, 9);  chk("nine_stays_above", o_above, 1'b1);
    cyc(1, 7); cyc(1, 7);
    chk("pend_dn_above", o_above, 1'b1);
    cyc(1, 7);
    chk("fall_pulse", o_fall,  1'b1);
    chk("fall_above", o_above, 1'b0);

    // saturated upper band: rise impossible
    cyc(0, 0, 1, 8190, 5);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8191);
      chk("sat_agb",  o_agb,  1'b1);
      chk("sat_rise", o_rise, 1'b0);
    end
    chk("sat_above", o_above, 1'b0);

    // restore T=10,H=2 and run the fall path with lower=8
    cyc(0, 0, 1, 10, 2);
    cyc(1, 13); cyc(1, 13); cyc(1, 13);
    chk("rise2", o_rise, 1'b1);
    cyc(1, 7); cyc(1, 7); cyc(1, 7);
    chk("fall2", o_fall, 1'b1);

    // load during PEND_UP aborts; run restarts from scratch
    cyc(1, 13); cyc(1, 13);
    cyc(0, 0, 1, 10, 2);
    chk("abort_above", o_above, 1'b0);
    chk("abort_rise",  o_rise,  1'b0);
    cyc(1, 13);
    chk("abort_restart", o_rise, 1'b0);
    cyc(1, 13);
    chk("abort_restart2", o_rise, 1'b0);
    cyc(1, 13);
    chk("abort_rise3", o_rise,  1'b1);
    chk("abort_above3", o_above, 1'b1);

    // reset pulse mid-cycle while in PEND_DN
    cyc(1, 7); cyc(1, 7);
    chk("pdn_above", o_above, 1'b1);
    i_valid = 0;
    #2 i_rst_n = 0;
    #1 chk_all_zero("async_rst");
    @(negedge i_clk);
    i_rst_n = 1;
    cyc(1, 7);
    chk("after_rst_no_fall", o_fall, 1'b0);
    cyc(1, 13); cyc(1, 13); cyc(1, 13);
    chk("after_rst_rise", o_rise, 1'b1);
    cyc(0, 0);
    cyc(0, 0);

    run_cmp = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/hyst_threshold_monitor.md
Name: hyst_threshold_monitor

Overview:
- Sequential successor to the fixed-constant comparator: registered equal/greater/less flags against a runtime-loadable threshold.
- Adds a hysteresis band and a persistence (debounce) filter producing a stable above/below state with one-cycle rise/fall event pulses.
- Sits between sample sources (ADC/counter datapaths) and control logic that needs glitch-free threshold crossings.

Parameters:
- DATA_WIDTH, 13, width of samples, threshold and hysteresis.
- THRESH_DEFAULT, 10, threshold value after reset.
- HYST_DEFAULT, 0, hysteresis half-band after reset.
- PERSIST, 3, consecutive qualifying valid samples needed to change state; legal range 1..255.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  sample qualifier.
- i_data_A  in  DATA_WIDTH  unsigned sample.
- i_thr_load  in  1  load i_thr and i_hyst.
- i_thr  in  DATA_WIDTH  new threshold T.
- i_hyst  in  DATA_WIDTH  new hysteresis H.
- o_valid  out  1  registered copy of i_valid.
- o_aeb / o_agb / o_alb  out  1 each  sample ==, >, < T; exactly one high per valid sample.
- o_above  out  1  filtered state, 1 = ABOVE.
- o_rise / o_fall  out  1 each  single-cycle transition pulses.

Behaviour:
- Reset (async assert, sync-to-clock deassert handled upstream): T=THRESH_DEFAULT, H=HYST_DEFAULT, state BELOW, counter 0, all outputs 0.
- Latency: sample accepted at edge k; all outputs for it visible after edge k (1 cycle).
- i_valid=0: o_valid=0 next cycle; flags, o_above, state and counter hold; o_rise/o_fall 0.
- Bands: upper = T+H saturated at 2^DATA_WIDTH-1; lower = T-H saturated at 0; computed at DATA_WIDTH+1 bits internally.
- Rise condition: sample > upper. Fall condition: sample < lower. With saturated upper, rise is impossible; with lower=0, fall is impossible.
- FSM states: BELOW, PEND_UP, ABOVE, PEND_DN; counter width ceil(log2(PERSIST+1)).
- BELOW: valid rise sample -> if PERSIST=1 go ABOVE and pulse o_rise, else PEND_UP with count 1.
- PEND_UP: valid rise sample -> count+1; on count reaching PERSIST go ABOVE, pulse o_rise, clear count. Valid non-rise sample -> BELOW, count 0.
- ABOVE / PEND_DN: mirror image with fall condition and o_fall.
- o_above = 1 in ABOVE and PEND_DN, 0 in BELOW and PEND_UP.
- i_thr_load: T/H update at the edge; a sample in the same cycle uses the old T/H; a pending state aborts to its stable state (PEND_UP->BELOW, PEND_DN->ABOVE), count 0, no pulse.
- o_rise and o_fall never high together; never high with o_valid=0.
- Reset mid-pending: immediate clear, no pulse.

Decomposition:
- Package hyst_monitor_pkg: state enum (BELOW, PEND_UP, ABOVE, PEND_DN) and counter-width function.
- One combinational sub-module band_compare: computes saturated upper/lower bands plus eq/gt/lt, rise and fall conditions; the top level holds the registers and FSM.

Test Plan (DATA_WIDTH=13, T=10, H=2, PERSIST=3):
- Reset with i_valid=1 and data 500 -> all outputs 0 while i_rst_n=0; after release, first output appears one cycle after the first valid.
- Valid 10, 11, 9, then idle -> o_aeb, o_agb, o_alb in successive cycles; idle cycle gives o_valid=0 with flags held.
- Valid 13,13,13 -> o_rise high exactly one cycle after the third sample and o_above=1. Sequence 13,13,11,13 -> no rise; state returns to BELOW on 11.
- From ABOVE: 9 (not < 8) -> no change; then 7,7,7 -> o_fall one cycle after the third sample and o_above=0.
- Load T=8190, H=5 -> upper saturates at 8191; four valid 8191 samples -> no rise, o_agb=1 each. Then load T=10, H=2 and data 7 -> fall path with lower=8.
- In PEND_UP (two samples of 13), assert i_thr_load -> BELOW, no pulse. In PEND_DN, pulse i_rst_n low mid-cycle -> outputs clear asynchronously.
